// File: rtl/dma_pkg.sv
// Shared encodings and default sizing for the DMA channel requester.
package dma_pkg;

    localparam int CH_NUM_DEF     = 4;
    localparam int ADDR_W_DEF     = 32;
    localparam int LEN_W_DEF      = 8;
    localparam int BEAT_BYTES_DEF = 4;
    localparam int CH_IDX_W       = $clog2(CH_NUM_DEF);

    typedef enum logic [1:0] {
        CH_IDLE   = 2'd0,
        CH_PEND   = 2'd1,
        CH_ACTIVE = 2'd2
    } ch_state_e;

    typedef enum logic {
        ENG_IDLE  = 1'b0,
        ENG_BURST = 1'b1
    } eng_state_e;

endpackage

// File: rtl/dma_chan_slot.sv
// One DMA channel: descriptor storage plus the IDLE/PEND/ACTIVE request FSM.
module dma_chan_slot
    import dma_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int LEN_W  = LEN_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_valid_i,
    input  logic [ADDR_W-1:0] cfg_addr_i,
    input  logic [LEN_W-1:0]  cfg_len_i,
    input  logic              grant_i,
    input  logic              last_acc_i,
    output logic [1:0]        state_o,
    output logic              req_o,
    output logic              done_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic [LEN_W-1:0]  len_o
);

    ch_state_e         state_q;
    logic              req_q;
    logic              done_q;
    logic [ADDR_W-1:0] addr_q;
    logic [LEN_W-1:0]  len_q;

    // req is a plain register so the combinational arbiter never sees a loop.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CH_IDLE;
            req_q   <= 1'b0;
            done_q  <= 1'b0;
            addr_q  <= '0;
            len_q   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                CH_IDLE: begin
                    if (cfg_valid_i) begin
                        if (cfg_len_i != '0) begin
                            addr_q  <= cfg_addr_i;
                            len_q   <= cfg_len_i;
                            req_q   <= 1'b1;
                            state_q <= CH_PEND;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                CH_PEND: begin
                    if (grant_i) begin
                        req_q   <= 1'b0;
                        state_q <= CH_ACTIVE;
                    end
                end
                CH_ACTIVE: begin
                    if (last_acc_i) begin
                        done_q  <= 1'b1;
                        state_q <= CH_IDLE;
                    end
                end
                default: begin
                    req_q   <= 1'b0;
                    state_q <= CH_IDLE;
                end
            endcase
        end
    end

    assign state_o = state_q;
    assign req_o   = req_q;
    assign done_o  = done_q;
    assign addr_o  = addr_q;
    assign len_o   = len_q;

endmodule

// File: rtl/dma_chan_requester.sv
// Requester side of DMA arbitration: per-channel slots feed reqs, the engine runs granted bursts.
module dma_chan_requester
    import dma_pkg::*;
#(
    parameter int CH_NUM     = CH_NUM_DEF,
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int LEN_W      = LEN_W_DEF,
    parameter int BEAT_BYTES = BEAT_BYTES_DEF,
    localparam int IDX_W     = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [CH_NUM-1:0]        cfg_valid,
    output logic [CH_NUM-1:0]        cfg_ready,
    input  logic [CH_NUM*ADDR_W-1:0] cfg_addr,
    input  logic [CH_NUM*LEN_W-1:0]  cfg_len,
    output logic [CH_NUM-1:0]        reqs,
    input  logic [CH_NUM-1:0]        grants,
    output logic                     bus_valid,
    input  logic                     bus_ready,
    output logic [ADDR_W-1:0]        bus_addr,
    output logic [IDX_W-1:0]         bus_ch,
    output logic                     bus_last,
    output logic [CH_NUM-1:0]        done
);

    logic [CH_NUM-1:0][ADDR_W-1:0] slot_addr;
    logic [CH_NUM-1:0][LEN_W-1:0]  slot_len;
    logic [CH_NUM-1:0][1:0]        slot_state;
    logic [CH_NUM-1:0]             slot_grant;
    logic [CH_NUM-1:0]             slot_last;

    eng_state_e        eng_q;
    logic [IDX_W-1:0]  ch_q;
    logic [ADDR_W-1:0] addr_q;
    logic [LEN_W-1:0]  cnt_q;

    logic [CH_NUM-1:0] eff;
    logic              pick_vld;
    logic [IDX_W-1:0]  pick_idx;
    logic              launch;
    logic              last_acc;

    // Only grants backed by our own request count; lowest index wins if several do.
    always_comb begin
        eff      = grants & reqs;
        pick_vld = 1'b0;
        pick_idx = '0;
        for (int i = CH_NUM - 1; i >= 0; i--) begin
            if (eff[i]) begin
                pick_vld = 1'b1;
                pick_idx = IDX_W'(i);
            end
        end
    end

    assign launch   = (eng_q == ENG_IDLE) && pick_vld;
    assign last_acc = (eng_q == ENG_BURST) && bus_ready && (cnt_q == LEN_W'(1));

    for (genvar g = 0; g < CH_NUM; g++) begin : g_slot
        assign slot_grant[g] = launch && (pick_idx == IDX_W'(g));
        assign slot_last[g]  = last_acc && (ch_q == IDX_W'(g));
        assign cfg_ready[g]  = (slot_state[g] == CH_IDLE);

        dma_chan_slot #(
            .ADDR_W (ADDR_W),
            .LEN_W  (LEN_W)
        ) u_slot (
            .clk         (clk),
            .rst         (rst),
            .cfg_valid_i (cfg_valid[g]),
            .cfg_addr_i  (cfg_addr[g*ADDR_W +: ADDR_W]),
            .cfg_len_i   (cfg_len[g*LEN_W +: LEN_W]),
            .grant_i     (slot_grant[g]),
            .last_acc_i  (slot_last[g]),
            .state_o     (slot_state[g]),
            .req_o       (reqs[g]),
            .done_o      (done[g]),
            .addr_o      (slot_addr[g]),
            .len_o       (slot_len[g])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            eng_q  <= ENG_IDLE;
            ch_q   <= '0;
            addr_q <= '0;
            cnt_q  <= '0;
        end else begin
            case (eng_q)
                ENG_IDLE: begin
                    if (pick_vld) begin
                        ch_q   <= pick_idx;
                        addr_q <= slot_addr[pick_idx];
                        cnt_q  <= slot_len[pick_idx];
                        eng_q  <= ENG_BURST;
                    end
                end
                ENG_BURST: begin
                    if (bus_ready) begin
                        addr_q <= addr_q + ADDR_W'(BEAT_BYTES);
                        cnt_q  <= cnt_q - LEN_W'(1);
                        if (cnt_q == LEN_W'(1)) begin
                            eng_q <= ENG_IDLE;
                        end
                    end
                end
                default: eng_q <= ENG_IDLE;
            endcase
        end
    end

    assign bus_valid = (eng_q == ENG_BURST);
    assign bus_last  = (eng_q == ENG_BURST) && (cnt_q == LEN_W'(1));
    assign bus_addr  = addr_q;
    assign bus_ch    = ch_q;

endmodule

// File: tb/tb_dma_chan_requester.sv
// Bench for dma_chan_requester: fixed-priority arbiter model, beat/done scoreboards.
module tb_dma_chan_requester;
    import dma_pkg::*;

    localparam int CH = 4;
    localparam int AW = 32;
    localparam int LW = 8;
    localparam int IW = CH_IDX_W;
    localparam int W  = IW + 1 + AW;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [CH-1:0]   cfg_valid = '0;
    logic [CH-1:0]   cfg_ready;
    logic [CH*AW-1:0] cfg_addr = '0;
    logic [CH*LW-1:0] cfg_len = '0;
    logic [CH-1:0]   reqs;
    logic [CH-1:0]   grants;
    logic            bus_valid;
    logic            bus_ready = 1'b1;
    logic [AW-1:0]   bus_addr;
    logic [IW-1:0]   bus_ch;
    logic            bus_last;
    logic [CH-1:0]   done;

    logic            force_en = 1'b0;
    logic [CH-1:0]   force_g = '0;

    logic [W-1:0]    exp_q[$];
    logic [IW-1:0]   done_exp_q[$];

    int total = 0;
    int bad = 0;
    int acc_cnt = 0;

    // Fixed-priority arbiter model (ch0 highest), overridable for robustness cases.
    assign grants = force_en ? force_g : (reqs & (~reqs + 4'd1));

    always #5 clk = ~clk;

    dma_chan_requester dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_addr  (cfg_addr),
        .cfg_len   (cfg_len),
        .reqs      (reqs),
        .grants    (grants),
        .bus_valid (bus_valid),
        .bus_ready (bus_ready),
        .bus_addr  (bus_addr),
        .bus_ch    (bus_ch),
        .bus_last  (bus_last),
        .done      (done)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Monitor on the falling edge: beats against exp_q head, done pulses against done_exp_q.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("beat_unexpected", 64'd1, 64'd0);
                end else begin
                    check("beat", {bus_ch, bus_last, bus_addr}, exp_q[0]);
                    if (bus_ready) begin
                        void'(exp_q.pop_front());
                        acc_cnt++;
                    end
                end
            end
            for (int i = 0; i < CH; i++) begin
                if (done[i] === 1'b1) begin
                    if (done_exp_q.size() == 0) check("done_unexpected", 64'(i), 64'hFF);
                    else check("done_ch", 64'(i), 64'(done_exp_q.pop_front()));
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_burst(input int ch, input logic [AW-1:0] a, input int len);
        logic [W-1:0] e;
        logic [IW-1:0] c;
        c = IW'(ch);
        for (int k = 0; k < len; k++) begin
            e = {c, (k == len - 1), a + AW'(4 * k)};
            exp_q.push_back(e);
        end
        done_exp_q.push_back(c);
    endtask

    task automatic set_desc(input int ch, input logic [AW-1:0] a, input logic [LW-1:0] len);
        check("cfg_ready_before_load", 64'(cfg_ready[ch]), 64'd1);
        cfg_valid[ch] = 1'b1;
        cfg_addr[ch*AW +: AW] = a;
        cfg_len[ch*LW +: LW] = len;
    endtask

    task automatic commit();
        step(1);
        cfg_valid = '0;
    endtask

    task automatic drain(input int budget);
        int c;
        c = 0;
        while (exp_q.size() != 0 || done_exp_q.size() != 0 || bus_valid !== 1'b0) begin
            if (c >= budget) begin
                check("drain_timeout", 64'(c), 64'(budget - 1));
                break;
            end
            step(1);
            c++;
        end
        step(1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        int base;
        logic [6:0] pat;

        // Reset state
        step(3);
        rst = 1'b0;
        step(1);
        check("rst_cfg_ready", 64'(cfg_ready), 64'hF);
        check("rst_reqs", 64'(reqs), 64'h0);
        check("rst_bus_valid", 64'(bus_valid), 64'h0);
        check("rst_bus_last", 64'(bus_last), 64'h0);
        check("rst_bus_addr", 64'(bus_addr), 64'h0);
        check("rst_bus_ch", 64'(bus_ch), 64'h0);
        check("rst_done", 64'(done), 64'h0);

        // Single channel, latency checks
        push_burst(2, 32'h1000, 3);
        set_desc(2, 32'h1000, 8'd3);
        commit();
        check("single_reqs", 64'(reqs), 64'h4);
        check("single_valid_pre", 64'(bus_valid), 64'h0);
        step(1);
        check("single_valid_grant", 64'(bus_valid), 64'h1);
        check("single_reqs_dropped", 64'(reqs), 64'h0);
        drain(40);
        check("single_reqs_end", 64'(reqs), 64'h0);

        // Contention: ch1 first by priority, then ch3
        push_burst(1, 32'h200, 2);
        push_burst(3, 32'h300, 1);
        set_desc(1, 32'h200, 8'd2);
        set_desc(3, 32'h300, 8'd1);
        commit();
        check("cont_reqs", 64'(reqs), 64'hA);
        drain(50);

        // Backpressure: ready pattern 1,0,0,1,1,0,1 from the first beat cycle
        push_burst(0, 32'h40, 4);
        set_desc(0, 32'h40, 8'd4);
        commit();
        step(1);
        check("bp_first_valid", 64'(bus_valid), 64'h1);
        base = acc_cnt;
        pat = 7'b1011001;
        for (int k = 0; k < 7; k++) begin
            bus_ready = pat[k];
            step(1);
        end
        bus_ready = 1'b1;
        check("bp_beats", 64'(acc_cnt - base), 64'd4);
        check("bp_done", 64'(done), 64'h1);
        check("bp_idle", 64'(bus_valid), 64'h0);
        drain(20);

        // Zero length
        done_exp_q.push_back(IW'(1));
        set_desc(1, 32'h500, 8'd0);
        commit();
        check("zero_reqs", 64'(reqs), 64'h0);
        check("zero_done", 64'(done), 64'h2);
        check("zero_ready", 64'(cfg_ready), 64'hF);
        drain(20);

        // Address wrap
        push_burst(0, 32'hFFFF_FFFC, 2);
        set_desc(0, 32'hFFFF_FFFC, 8'd2);
        commit();
        drain(40);

        // Non-one-hot grant: lowest requested index wins
        force_en = 1'b1;
        force_g = 4'b1010;
        push_burst(1, 32'h600, 1);
        push_burst(3, 32'h700, 2);
        set_desc(1, 32'h600, 8'd1);
        set_desc(3, 32'h700, 8'd2);
        commit();
        step(1);
        check("multi_grant_valid", 64'(bus_valid), 64'h1);
        check("multi_grant_ch", 64'(bus_ch), 64'h1);
        drain(40);

        // Unrequested grant ignored
        force_g = 4'b0001;
        for (int k = 0; k < 4; k++) begin
            step(1);
            check("stray_grant_idle", 64'(bus_valid), 64'h0);
        end
        check("stray_grant_reqs", 64'(reqs), 64'h0);
        force_en = 1'b0;

        // Reset during beat 2 of a 5-beat burst
        push_burst(3, 32'h2000, 5);
        set_desc(3, 32'h2000, 8'd5);
        commit();
        base = acc_cnt;
        c = 0;
        while (acc_cnt < base + 1) begin
            if (c >= 50) begin
                check("rst_wait_timeout", 64'(c), 64'd49);
                break;
            end
            step(1);
            c++;
        end
        rst = 1'b1;
        step(1);
        check("midrst_valid", 64'(bus_valid), 64'h0);
        check("midrst_reqs", 64'(reqs), 64'h0);
        check("midrst_ready", 64'(cfg_ready), 64'hF);
        check("midrst_done", 64'(done), 64'h0);
        exp_q.delete();
        done_exp_q.delete();
        rst = 1'b0;
        step(3);
        push_burst(3, 32'h3000, 2);
        set_desc(3, 32'h3000, 8'd2);
        commit();
        drain(40);

        check("end_beats_left", 64'(exp_q.size()), 64'd0);
        check("end_done_left", 64'(done_exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
